multi_interrupt_controller: RTL and testbench
=============================================

// Module: multi_interrupt_controller
// PURPOSE
//  Multi-source, masked, fixed-priority interrupt controller for the RV32IMC pipeline; successor to the single-line ISR controller.
//  Latches falling edges on NUM_IRQ active-low lines, selects one source, stalls the fetch stage while the pipeline drains,
//  captures the return PC, and steers the PC mux to the ISR and back on URET. Sits beside the PC/IF stage and the hazard unit.
// PARAMETERS
//  PC_W          12  width of PC and save_pc
//  NUM_IRQ        4  number of interrupt lines (1..16)
//  IDX_W          2  width of isr_idx; must equal max(1,clog2(NUM_IRQ))
//  DRAIN_CYCLES   3  if_clk_en-qualified drain cycles on entry and on exit (2..7)
// PORTS
//  clk           in   1        clock
//  nrst          in   1        synchronous active-low reset
//  PC            in   PC_W     current PC from the PC module
//  if_opcode     in   7        IF-stage opcode; 7'h73 = URET
//  irq_n         in   NUM_IRQ  interrupt lines, active-low, synchronous to clk
//  irq_mask      in   NUM_IRQ  1 = source enabled
//  exe_correction in  2        EXE branch correction (nonzero = redirect)
//  if_prediction in   1        IF branch-predictor redirect
//  id_sel_pc     in   1        ID jump redirect
//  if_clk_en     in   1        IF-stage advance enable
//  isr_stall     out  1        stall request to the hazard unit
//  sel_isr       out  1        PC mux selects the ISR vector
//  ret_isr       out  1        PC mux selects save_pc
//  isr_idx       out  IDX_W    index of the source in service
//  save_pc       out  PC_W     captured return PC
//  irq_pending   out  NUM_IRQ  latched, not-yet-serviced edges
// BEHAVIOUR
//  Reset (nrst=0 at posedge):
//   - All outputs 0; state IDLE; drain counter 0.
//   - Edge-detect regs = all ones, so no spurious edge on release.
//  Edge latch:
//   - irq_pending[i] sets on a 1->0 transition of irq_n[i], independent of mask and state.
//   - Clears only when source i is accepted; a set and a clear of the same bit in one cycle -> set wins.
//  Selection:
//   - Candidates = irq_pending & irq_mask; lowest index has highest priority.
//   - No nesting: candidates are ignored outside IDLE.
//  FSM:
//   - IDLE: any candidate -> ENTER.
//     - Same edge: isr_idx <= winner; clear its pending bit; save_pc <= PC; counter <= 1.
//   - ENTER: isr_stall=1.
//     - Counter increments only when if_clk_en.
//     - Any redirect (exe_correction!=0 | if_prediction | id_sel_pc) -> save_pc <= PC that cycle.
//     - Counter==DRAIN_CYCLES -> RUN; counter <= 0; sel_isr <= 1.
//   - RUN: sel_isr=1.
//     - if_opcode==7'h73 -> isr_stall=1 combinationally that cycle.
//     - Next edge: EXIT; ret_isr <= 1; sel_isr <= 0; counter <= 1.
//   - EXIT: isr_stall=1; counter increments as in ENTER.
//     - Counter==DRAIN_CYCLES -> IDLE; ret_isr <= 0; counter <= 0.
//  Timing:
//   - Entry latency: 1 cycle from the latching edge to isr_stall.
//   - A candidate present at the IDLE return edge is accepted the following cycle.
//  Boundaries:
//   - URET (7'h73) in IDLE, ENTER or EXIT: ignored; no stall, no state change.
//   - if_clk_en=0: counter holds, stall is held.
//   - Mask cleared while a bit is pending: bit is retained and serviced when unmasked.
//   - Reset mid-ISR: all state is dropped, including the pending bits.
// STRUCTURE
//  - interrupt_defs.vh: FSM state localparams (IDLE=0, ENTER=1, RUN=2, EXIT=3) and URET_OPCODE=7'h73; shared with the hazard unit.
//  - Sub-module irq_priority_encoder #(NUM_IRQ, IDX_W): purely combinational; candidates -> {valid, idx}.
//  - Top module holds the edge detect, pending register, FSM, counter and save_pc.
// TESTING
//  1. Reset, irq_n=4'hF, if_clk_en=1, then irq_n[2] falls, mask=F, PC=12'h040
//     -> ENTER next cycle, isr_idx=2, save_pc=040, isr_stall for 3 cycles, then sel_isr=1.
//  2. irq_n[3] and irq_n[1] fall together
//     -> idx 1 serviced; pending=4'b1000 held; after URET+EXIT, idx 3 is accepted the next cycle.
//  3. During ENTER, exe_correction=2'b01 with PC=12'h0A4
//     -> save_pc=0A4; counter is not reset.
//  4. In RUN, if_opcode=7'h73
//     -> isr_stall=1 that cycle; ret_isr=1 for 3 enabled cycles; then IDLE, ret_isr=0.
//  5. During ENTER, if_clk_en low 2 cycles
//     -> drain extends by 2; URET in IDLE has no effect.
//  6. mask=0 with edge on line 0
//     -> pending=1, no entry; set mask -> entry.
//     -> nrst=0 mid-RUN: all outputs 0 next cycle, pending cleared.

Source files
------------

// File: rtl/multi_interrupt_controller_pkg.sv
// Shared definitions for the multi-source interrupt controller: FSM states,
// the URET opcode and the width of the drain counter.
package multi_interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RUN   = 2'd2,
        ST_EXIT  = 2'd3
    } isr_state_t;

    localparam logic [6:0] URET_OPCODE = 7'h73;

    // Drain length is at most 7, so a 3-bit counter covers every setting.
    localparam int CNT_W = 3;

endpackage

// File: rtl/multi_interrupt_controller_irq_priority_encoder.sv
// Fixed-priority encoder: the lowest-numbered asserted candidate wins.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_IRQ-1:0] cand,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the last hit left in idx is the lowest index.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/multi_interrupt_controller.sv
// Masked fixed-priority interrupt controller. Latches falling edges on the
// active-low request lines, drains the pipeline before steering the PC mux
// to the ISR, and drains again on URET before returning to save_pc.
module multi_interrupt_controller
    import multi_interrupt_controller_pkg::*;
#(
    parameter int PC_W         = 12,
    parameter int NUM_IRQ      = 4,
    parameter int IDX_W        = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [PC_W-1:0]    PC,
    input  logic [6:0]         if_opcode,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [1:0]         exe_correction,
    input  logic               if_prediction,
    input  logic               id_sel_pc,
    input  logic               if_clk_en,
    output logic               isr_stall,
    output logic               sel_isr,
    output logic               ret_isr,
    output logic [IDX_W-1:0]   isr_idx,
    output logic [PC_W-1:0]    save_pc,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    isr_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_n_q;
    logic [NUM_IRQ-1:0] fall;
    logic [NUM_IRQ-1:0] clr;
    logic [PC_W-1:0]    save_q, save_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sel_q, sel_d;
    logic               ret_q, ret_d;
    logic               cand_vld;
    logic [IDX_W-1:0]   cand_idx;
    logic               redirect;

    assign fall     = irq_n_q & ~irq_n;
    assign redirect = (exe_correction != 2'b00) | if_prediction | id_sel_pc;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio (
        .cand  (pend_q & irq_mask),
        .valid (cand_vld),
        .idx   (cand_idx)
    );

    // Next-state, drain counter, return-PC capture and the stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        save_d    = save_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        ret_d     = ret_q;
        clr       = '0;
        isr_stall = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cand_vld) begin
                    state_d       = ST_ENTER;
                    idx_d         = cand_idx;
                    clr[cand_idx] = 1'b1;
                    save_d        = PC;
                    cnt_d         = CNT_ONE;
                end
            end
            ST_ENTER: begin
                isr_stall = 1'b1;
                // A redirect during drain means the older return PC was squashed.
                if (redirect) begin
                    save_d = PC;
                end
                if (if_clk_en) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        sel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (if_opcode == URET_OPCODE) begin
                    isr_stall = 1'b1;
                    state_d   = ST_EXIT;
                    ret_d     = 1'b1;
                    sel_d     = 1'b0;
                    cnt_d     = CNT_ONE;
                end
            end
            ST_EXIT: begin
                isr_stall = 1'b1;
                if (if_clk_en) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = ST_IDLE;
                        ret_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new edge on the source being accepted must not be lost.
        pend_d = (pend_q & ~clr) | fall;
    end

    // State, pending and edge-detect registers; reset drops everything.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            irq_n_q <= '1;
            save_q  <= '0;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            irq_n_q <= irq_n;
            save_q  <= save_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            ret_q   <= ret_d;
        end
    end

    assign sel_isr     = sel_q;
    assign ret_isr     = ret_q;
    assign isr_idx     = idx_q;
    assign save_pc     = save_q;
    assign irq_pending = pend_q;

endmodule

// File: tb/tb_multi_interrupt_controller.sv
// Bench for multi_interrupt_controller: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_multi_interrupt_controller;

    localparam int PC_W    = 12;
    localparam int NUM_IRQ = 4;
    localparam int IDX_W   = 2;
    localparam int DRAIN   = 3;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [PC_W-1:0]   PC = '0;
    logic [6:0]        if_opcode = '0;
    logic [3:0]        irq_n = 4'hF;
    logic [3:0]        irq_mask = 4'hF;
    logic [1:0]        exe_correction = '0;
    logic              if_prediction = 1'b0;
    logic              id_sel_pc = 1'b0;
    logic              if_clk_en = 1'b1;
    logic              isr_stall, sel_isr, ret_isr;
    logic [IDX_W-1:0]  isr_idx;
    logic [PC_W-1:0]   save_pc;
    logic [3:0]        irq_pending;

    int n_checks = 0;
    int n_errors = 0;

    multi_interrupt_controller #(
        .PC_W(PC_W), .NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .nrst(nrst), .PC(PC), .if_opcode(if_opcode), .irq_n(irq_n),
        .irq_mask(irq_mask), .exe_correction(exe_correction),
        .if_prediction(if_prediction), .id_sel_pc(id_sel_pc), .if_clk_en(if_clk_en),
        .isr_stall(isr_stall), .sel_isr(sel_isr), .ret_isr(ret_isr),
        .isr_idx(isr_idx), .save_pc(save_pc), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: servicing phases as flags, drain as a countdown of
    // enabled cycles still owed.
    bit          m_valid = 0;
    bit          m_ent, m_run, m_ext;
    int          m_left;
    logic [1:0]  m_idx;
    logic [11:0] m_save;
    logic [3:0]  m_pend, m_prev;

    always @(posedge clk) begin : model
        logic [3:0] fall;
        logic [3:0] cand;
        int         w;
        if (!nrst) begin
            m_valid = 1; m_ent = 0; m_run = 0; m_ext = 0; m_left = 0;
            m_idx = '0; m_save = '0; m_pend = '0; m_prev = 4'hF;
        end else begin
            fall = m_prev & ~irq_n;
            if (!m_ent && !m_run && !m_ext) begin
                cand = m_pend & irq_mask;
                if (cand != 4'b0) begin
                    w = 0;
                    while (!cand[w]) w++;
                    m_idx     = 2'(w);
                    m_pend[w] = 1'b0;
                    m_save    = PC;
                    m_ent     = 1;
                    m_left    = DRAIN;
                end
            end else if (m_ent) begin
                if (exe_correction != 2'b00 || if_prediction || id_sel_pc) m_save = PC;
                if (if_clk_en) begin
                    m_left--;
                    if (m_left == 0) begin m_ent = 0; m_run = 1; end
                end
            end else if (m_run) begin
                if (if_opcode == 7'h73) begin m_run = 0; m_ext = 1; m_left = DRAIN; end
            end else begin
                if (if_clk_en) begin
                    m_left--;
                    if (m_left == 0) m_ext = 0;
                end
            end
            m_pend = m_pend | fall;
            m_prev = irq_n;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_stall;
        if (m_valid) begin
            exp_stall = m_ent || m_ext || (m_run && if_opcode == 7'h73);
            n_checks++;
            if (isr_stall !== exp_stall || sel_isr !== m_run || ret_isr !== m_ext ||
                isr_idx !== m_idx || save_pc !== m_save || irq_pending !== m_pend) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t actual stall=%b sel=%b ret=%b idx=%0d save=%h pend=%b required stall=%b sel=%b ret=%b idx=%0d save=%h pend=%b",
                         $time, isr_stall, sel_isr, ret_isr, isr_idx, save_pc, irq_pending,
                         exp_stall, m_run, m_ext, m_idx, m_save, m_pend);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset
        nrst = 1'b0;
        steps(2);
        chk("rst_stall", isr_stall, 0);
        chk("rst_sel", sel_isr, 0);
        chk("rst_ret", ret_isr, 0);
        chk("rst_idx", isr_idx, 0);
        chk("rst_save", save_pc, 0);
        chk("rst_pend", irq_pending, 0);
        nrst = 1'b1;
        step();

        // Single source entry and URET exit
        PC = 12'h040; irq_n = 4'b1011;
        step();
        chk("t1_pend_latch", irq_pending, 4'b0100);
        chk("t1_no_stall_yet", isr_stall, 0);
        step();
        chk("t1_stall", isr_stall, 1);
        chk("t1_idx", isr_idx, 2);
        chk("t1_save", save_pc, 12'h040);
        chk("t1_pend_clr", irq_pending, 0);
        steps(2);
        chk("t1_stall_last", isr_stall, 1);
        step();
        chk("t1_sel", sel_isr, 1);
        chk("t1_run_nostall", isr_stall, 0);
        if_opcode = 7'h73; #1;
        chk("t4_uret_stall", isr_stall, 1);
        step(); if_opcode = 7'h00;
        chk("t4_ret", ret_isr, 1);
        chk("t4_sel_off", sel_isr, 0);
        steps(2);
        chk("t4_ret_hold", ret_isr, 1);
        step();
        chk("t4_ret_off", ret_isr, 0);
        chk("t4_idle_nostall", isr_stall, 0);
        if_opcode = 7'h73; #1;
        chk("t5_uret_idle", isr_stall, 0);
        step(); if_opcode = 7'h00;
        chk("t5_uret_idle_next", isr_stall, 0);

        // Two simultaneous sources: lower index first, higher kept pending
        irq_n = 4'b0101;
        step();
        chk("t2_pend_both", irq_pending, 4'b1010);
        step();
        chk("t2_idx1", isr_idx, 1);
        chk("t2_pend_hold", irq_pending, 4'b1000);
        steps(3);
        chk("t2_sel", sel_isr, 1);
        if_opcode = 7'h73;
        step(); if_opcode = 7'h00;
        steps(3);
        chk("t2_back_idle", ret_isr, 0);
        step();
        chk("t2_idx3", isr_idx, 3);
        chk("t2_stall3", isr_stall, 1);
        chk("t2_pend_empty", irq_pending, 0);

        // Redirect during entry drain recaptures PC without restarting drain
        PC = 12'h0A4; exe_correction = 2'b01; irq_n = 4'b0100;
        step(); exe_correction = 2'b00; PC = '0;
        chk("t3_save", save_pc, 12'h0A4);
        chk("t3_new_pend", irq_pending, 4'b0001);
        step();
        chk("t3_stall", isr_stall, 1);
        step();
        chk("t3_sel", sel_isr, 1);

        // Reset in the middle of a service routine
        nrst = 1'b0;
        step();
        chk("t6_rst_sel", sel_isr, 0);
        chk("t6_rst_pend", irq_pending, 0);
        chk("t6_rst_idx", isr_idx, 0);
        chk("t6_rst_save", save_pc, 0);
        nrst = 1'b1; irq_n = 4'hF;
        step();

        // if_clk_en low during entry stretches the drain
        irq_n = 4'b1110;
        steps(2);
        if_clk_en = 1'b0;
        steps(2);
        if_clk_en = 1'b1;
        steps(2);
        chk("t5_stretched_stall", isr_stall, 1);
        chk("t5_stretched_nosel", sel_isr, 0);
        step();
        chk("t5_sel", sel_isr, 1);
        if_opcode = 7'h73;
        step(); if_opcode = 7'h00;
        steps(3);
        irq_n = 4'hF;
        step();

        // Masked source is retained until unmasked
        irq_mask = 4'h0; irq_n = 4'b1110;
        steps(2);
        chk("t6_masked_pend", irq_pending, 4'b0001);
        chk("t6_masked_nostall", isr_stall, 0);
        irq_mask = 4'hF;
        step();
        chk("t6_unmask_stall", isr_stall, 1);
        chk("t6_unmask_idx", isr_idx, 0);

        // Randomized traffic checked by the model
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] flip;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom % 6) == 0;
            irq_n          = irq_n ^ flip;
            irq_mask       = ($urandom % 10 == 0) ? 4'($urandom) : 4'hF;
            if_clk_en      = ($urandom % 4) != 0;
            if_opcode      = ($urandom % 6 == 0) ? 7'h73 : 7'($urandom);
            exe_correction = ($urandom % 10 == 0) ? 2'($urandom) : 2'b00;
            if_prediction  = ($urandom % 12) == 0;
            id_sel_pc      = ($urandom % 12) == 0;
            PC             = 12'($urandom);
            nrst           = ($urandom % 400) != 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
